// File: rtl/mc_controller_if.sv
// rtl/mc_controller_if.sv - decode inputs and control outputs shared between controller and datapath
interface mc_controller_if;
    logic [5:0] Instruction_class;
    logic [5:0] func;
    logic       ZERO;
    logic [1:0] MemtoReg;
    logic       MemRead;
    logic       MemWrite;
    logic       ALU_SRC;
    logic [3:0] ALUop;
    logic [1:0] RegDst;
    logic [1:0] NPCop;
    logic       RegWrite;
    logic       Extop;
    logic       IRWrite;
    logic       PCWrite;
    logic       instr_done;

    modport master (
        input  Instruction_class, func, ZERO,
        output MemtoReg, MemRead, MemWrite, ALU_SRC, ALUop, RegDst, NPCop,
               RegWrite, Extop, IRWrite, PCWrite, instr_done
    );

    modport slave (
        output Instruction_class, func, ZERO,
        input  MemtoReg, MemRead, MemWrite, ALU_SRC, ALUop, RegDst, NPCop,
               RegWrite, Extop, IRWrite, PCWrite, instr_done
    );
endinterface

// File: rtl/mc_controller.sv
// rtl/mc_controller.sv - multi-cycle IF/ID/EX/MEM/WB control unit for the MIPS-subset core
module mc_controller (
    input  logic              clk,
    input  logic              reset,
    mc_controller_if.master   bus
);
    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EX  = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_t;

    typedef enum logic [3:0] {
        I_NOP, I_ADDU, I_SUBU, I_JR, I_ORI, I_LUI,
        I_LW, I_SW, I_BEQ, I_J, I_JAL
    } instr_t;

    state_t     r_state;
    state_t     w_next;
    instr_t     w_instr;
    logic [3:0] w_alu_op;
    logic       w_alu_src;
    logic       w_extop;
    logic [1:0] w_memtoreg;
    logic       w_memread;
    logic       w_memwrite;
    logic       w_alu_src_o;
    logic [3:0] w_alu_op_o;
    logic [1:0] w_regdst;
    logic [1:0] w_npcop;
    logic       w_regwrite;
    logic       w_extop_o;
    logic       w_irwrite;
    logic       w_pcwrite;

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IF;
        else       r_state <= w_next;
    end

    always_comb begin
        w_instr = I_NOP;
        case (bus.Instruction_class)
            6'b000000: begin
                case (bus.func)
                    6'b100001: w_instr = I_ADDU;
                    6'b100011: w_instr = I_SUBU;
                    6'b001000: w_instr = I_JR;
                    default:   w_instr = I_NOP;
                endcase
            end
            6'b001101: w_instr = I_ORI;
            6'b001111: w_instr = I_LUI;
            6'b100011: w_instr = I_LW;
            6'b101011: w_instr = I_SW;
            6'b000100: w_instr = I_BEQ;
            6'b000010: w_instr = I_J;
            6'b000011: w_instr = I_JAL;
            default:   w_instr = I_NOP;
        endcase
    end

    // ALU controls depend only on the instruction; they are held through EX, MEM and WB
    always_comb begin
        w_alu_op  = 4'b0000;
        w_alu_src = 1'b0;
        w_extop   = 1'b0;
        case (w_instr)
            I_SUBU:      w_alu_op = 4'b0001;
            I_ORI:       begin w_alu_op = 4'b0010; w_alu_src = 1'b1; end
            I_LUI:       begin w_alu_op = 4'b0011; w_alu_src = 1'b1; end
            I_LW, I_SW:  begin w_alu_src = 1'b1; w_extop = 1'b1; end
            I_BEQ:       begin w_alu_op = 4'b0001; w_extop = 1'b1; end
            default:     w_alu_op = 4'b0000;
        endcase
    end

    always_comb begin
        w_next      = S_IF;
        w_memtoreg  = 2'b00;
        w_memread   = 1'b0;
        w_memwrite  = 1'b0;
        w_alu_src_o = 1'b0;
        w_alu_op_o  = 4'b0000;
        w_regdst    = 2'b00;
        w_npcop     = 2'b00;
        w_regwrite  = 1'b0;
        w_extop_o   = 1'b0;
        w_irwrite   = 1'b0;
        w_pcwrite   = 1'b0;
        if (!reset) begin
            case (r_state)
                S_IF: begin
                    w_irwrite = 1'b1;
                    w_next    = S_ID;
                end
                S_ID: begin
                    case (w_instr)
                        I_J: begin
                            w_pcwrite = 1'b1;
                            w_npcop   = 2'b10;
                        end
                        I_JAL: begin
                            w_pcwrite  = 1'b1;
                            w_npcop    = 2'b10;
                            w_regwrite = 1'b1;
                            w_regdst   = 2'b10;
                            w_memtoreg = 2'b10;
                        end
                        I_JR: begin
                            w_pcwrite = 1'b1;
                            w_npcop   = 2'b11;
                        end
                        I_NOP: w_pcwrite = 1'b1;
                        default: w_next = S_EX;
                    endcase
                end
                S_EX: begin
                    w_alu_op_o  = w_alu_op;
                    w_alu_src_o = w_alu_src;
                    w_extop_o   = w_extop;
                    case (w_instr)
                        I_ADDU, I_SUBU, I_ORI, I_LUI: w_next = S_WB;
                        I_LW, I_SW:                   w_next = S_MEM;
                        I_BEQ: begin
                            w_pcwrite = 1'b1;
                            w_npcop   = bus.ZERO ? 2'b01 : 2'b00;
                        end
                        default: w_next = S_IF;
                    endcase
                end
                S_MEM: begin
                    w_alu_op_o  = w_alu_op;
                    w_alu_src_o = w_alu_src;
                    w_extop_o   = w_extop;
                    case (w_instr)
                        I_LW: begin
                            w_memread = 1'b1;
                            w_next    = S_WB;
                        end
                        I_SW: begin
                            w_memwrite = 1'b1;
                            w_pcwrite  = 1'b1;
                        end
                        default: w_next = S_IF;
                    endcase
                end
                S_WB: begin
                    w_alu_op_o  = w_alu_op;
                    w_alu_src_o = w_alu_src;
                    w_extop_o   = w_extop;
                    w_regwrite  = 1'b1;
                    w_pcwrite   = 1'b1;
                    case (w_instr)
                        I_ADDU, I_SUBU: w_regdst = 2'b01;
                        I_LW: begin
                            w_memtoreg = 2'b01;
                            w_memread  = 1'b1;
                        end
                        default: w_regdst = 2'b00;
                    endcase
                end
                default: w_next = S_IF;
            endcase
        end
    end

    assign bus.MemtoReg   = w_memtoreg;
    assign bus.MemRead    = w_memread;
    assign bus.MemWrite   = w_memwrite;
    assign bus.ALU_SRC    = w_alu_src_o;
    assign bus.ALUop      = w_alu_op_o;
    assign bus.RegDst     = w_regdst;
    assign bus.NPCop      = w_npcop;
    assign bus.RegWrite   = w_regwrite;
    assign bus.Extop      = w_extop_o;
    assign bus.IRWrite    = w_irwrite;
    assign bus.PCWrite    = w_pcwrite;
    assign bus.instr_done = w_pcwrite;
endmodule

// File: tb/tb_mc_controller.sv
// tb/tb_mc_controller.sv - directed and random instruction sequences against a per-instruction cycle-list model
module tb_mc_controller;
    logic clk;
    logic reset;

    mc_controller_if ifc ();

    mc_controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] memtoreg;
        logic       memread;
        logic       memwrite;
        logic       alu_src;
        logic [3:0] aluop;
        logic [1:0] regdst;
        logic [1:0] npcop;
        logic       regwrite;
        logic       extop;
        logic       irwrite;
        logic       pcwrite;
        logic       instr_done;
    } ctl_t;

    int   n_cmp;
    int   n_err;
    ctl_t exp_q[$];
    logic [5:0] tab_op [9];
    logic [5:0] tab_fn [9];

    function automatic ctl_t observed();
        ctl_t c;
        c.memtoreg   = ifc.MemtoReg;
        c.memread    = ifc.MemRead;
        c.memwrite   = ifc.MemWrite;
        c.alu_src    = ifc.ALU_SRC;
        c.aluop      = ifc.ALUop;
        c.regdst     = ifc.RegDst;
        c.npcop      = ifc.NPCop;
        c.regwrite   = ifc.RegWrite;
        c.extop      = ifc.Extop;
        c.irwrite    = ifc.IRWrite;
        c.pcwrite    = ifc.PCWrite;
        c.instr_done = ifc.instr_done;
        return c;
    endfunction

    // Expected output for every cycle of one instruction, IF first; the final cycle retires it
    task automatic build(input logic [5:0] op, input logic [5:0] fn, input logic z);
        string kind;
        ctl_t  c_if, base, alu, c;
        kind = "nop";
        if (op == 6'b000000) begin
            if (fn == 6'b100001)      kind = "addu";
            else if (fn == 6'b100011) kind = "subu";
            else if (fn == 6'b001000) kind = "jr";
        end
        else if (op == 6'b001101) kind = "ori";
        else if (op == 6'b001111) kind = "lui";
        else if (op == 6'b100011) kind = "lw";
        else if (op == 6'b101011) kind = "sw";
        else if (op == 6'b000100) kind = "beq";
        else if (op == 6'b000010) kind = "j";
        else if (op == 6'b000011) kind = "jal";

        c_if = '0;
        c_if.irwrite = 1'b1;
        base = '0;
        alu  = '0;
        if (kind == "subu") alu.aluop = 4'd1;
        if (kind == "ori")  begin alu.aluop = 4'd2; alu.alu_src = 1'b1; end
        if (kind == "lui")  begin alu.aluop = 4'd3; alu.alu_src = 1'b1; end
        if (kind == "lw" || kind == "sw") begin alu.alu_src = 1'b1; alu.extop = 1'b1; end
        if (kind == "beq")  begin alu.aluop = 4'd1; alu.extop = 1'b1; end

        exp_q = {};
        exp_q.push_back(c_if);
        if (kind == "nop") exp_q.push_back(base);
        else if (kind == "j" || kind == "jr") begin
            c = base;
            c.npcop = (kind == "j") ? 2'b10 : 2'b11;
            exp_q.push_back(c);
        end
        else if (kind == "jal") begin
            c = base;
            c.npcop = 2'b10; c.regwrite = 1'b1; c.regdst = 2'b10; c.memtoreg = 2'b10;
            exp_q.push_back(c);
        end
        else if (kind == "beq") begin
            exp_q.push_back(base);
            c = alu;
            c.npcop = z ? 2'b01 : 2'b00;
            exp_q.push_back(c);
        end
        else if (kind == "sw") begin
            exp_q.push_back(base);
            exp_q.push_back(alu);
            c = alu; c.memwrite = 1'b1;
            exp_q.push_back(c);
        end
        else if (kind == "lw") begin
            exp_q.push_back(base);
            exp_q.push_back(alu);
            c = alu; c.memread = 1'b1;
            exp_q.push_back(c);
            c.memtoreg = 2'b01; c.regwrite = 1'b1;
            exp_q.push_back(c);
        end
        else begin
            exp_q.push_back(base);
            exp_q.push_back(alu);
            c = alu; c.regwrite = 1'b1;
            c.regdst = (kind == "addu" || kind == "subu") ? 2'b01 : 2'b00;
            exp_q.push_back(c);
        end
        c = exp_q[exp_q.size() - 1];
        c.pcwrite    = 1'b1;
        c.instr_done = 1'b1;
        exp_q[exp_q.size() - 1] = c;
    endtask

    task automatic check(input string tag, input int cyc, input ctl_t e);
        ctl_t o;
        o = observed();
        n_cmp++;
        assert (o === e) else begin
            n_err++;
            $error("FAIL %s cyc%0d observed=%h expected=%h", tag, cyc, o, e);
        end
    endtask

    // Entered #1 after an edge with the controller in IF; leaves it the same way
    task automatic run_instr(input string tag, input logic [5:0] op, input logic [5:0] fn, input logic z);
        build(op, fn, z);
        ifc.Instruction_class = op;
        ifc.func              = fn;
        for (int i = 0; i < exp_q.size(); i++) begin
            ifc.ZERO = (i == 2) ? z : 1'($urandom);
            @(negedge clk);
            check(tag, i, exp_q[i]);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        tab_op[0] = 6'b000000; tab_fn[0] = 6'b100001;
        tab_op[1] = 6'b000000; tab_fn[1] = 6'b100011;
        tab_op[2] = 6'b000000; tab_fn[2] = 6'b001000;
        tab_op[3] = 6'b001101; tab_fn[3] = 6'b000000;
        tab_op[4] = 6'b001111; tab_fn[4] = 6'b000000;
        tab_op[5] = 6'b100011; tab_fn[5] = 6'b000000;
        tab_op[6] = 6'b101011; tab_fn[6] = 6'b000000;
        tab_op[7] = 6'b000100; tab_fn[7] = 6'b000000;
        tab_op[8] = 6'b000011; tab_fn[8] = 6'b000000;

        reset = 1'b1;
        ifc.Instruction_class = 6'($urandom);
        ifc.func              = 6'($urandom);
        ifc.ZERO              = 1'($urandom);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("reset", i, '0);
            ifc.Instruction_class = 6'($urandom);
            ifc.func              = 6'($urandom);
            @(posedge clk);
        end
        #1;
        reset = 1'b0;

        run_instr("addu",     6'b000000, 6'b100001, 1'b0);
        run_instr("lw",       6'b100011, 6'b010101, 1'b1);
        run_instr("beq_z1",   6'b000100, 6'b000000, 1'b1);
        run_instr("beq_z0",   6'b000100, 6'b000000, 1'b0);
        run_instr("jal",      6'b000011, 6'b111000, 1'b0);
        run_instr("jr",       6'b000000, 6'b001000, 1'b1);
        run_instr("subu",     6'b000000, 6'b100011, 1'b1);
        run_instr("ori",      6'b001101, 6'b000000, 1'b0);
        run_instr("lui",      6'b001111, 6'b000000, 1'b0);
        run_instr("j",        6'b000010, 6'b000000, 1'b0);
        run_instr("sll_nop",  6'b000000, 6'b000000, 1'b0);
        run_instr("rfunc_unk",6'b000000, 6'b101010, 1'b0);

        build(6'b101011, 6'b000000, 1'b0);
        ifc.Instruction_class = 6'b101011;
        ifc.func              = 6'b000000;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("sw_abort", i, exp_q[i]);
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        @(negedge clk);
        check("sw_abort_mem", 3, '0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        run_instr("after_abort", 6'b000000, 6'b100001, 1'b0);

        run_instr("illegal", 6'b111111, 6'b000000, 1'b1);

        for (int k = 0; k < 60; k++) begin
            logic [5:0] op, fn;
            int idx;
            idx = int'($urandom_range(0, 11));
            if (idx >= 9) begin
                op = 6'($urandom);
                fn = 6'($urandom);
            end
            else begin
                op = tab_op[idx];
                fn = (op == 6'b000000) ? tab_fn[idx] : 6'($urandom);
            end
            run_instr($sformatf("rand%0d_op%b_fn%b", k, op, fn), op, fn, 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/mc_controller.md
# mc_controller

Multi-cycle control unit for the single-issue MIPS-subset core: the consumer of the datapath's decode outputs (`Instruction_class`, `func`, `ZERO`) and the producer of every control input that datapath takes. The controller sequences each instruction through a fetch/decode/execute/memory/writeback state machine and asserts per-state enables (`IRWrite`, `PCWrite`, `MemWrite`, `RegWrite`). One instance sits beside the datapath in the top-level CPU.

## Interface
- No parameters; all encodings are fixed below.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `Instruction_class` in 6: opcode field of the IR.
- `func` in 6: funct field of the IR.
- `ZERO` in 1: ALU result equals zero.
- `MemtoReg` out 2: GPR write source; 00 ALU, 01 DM, 10 PC+4.
- `MemRead` out 1: DM read enable.
- `MemWrite` out 1: DM write enable.
- `ALU_SRC` out 1: 0 = rt, 1 = extended immediate.
- `ALUop` out 4: 0000 add, 0001 sub, 0010 or, 0011 lui (imm<<16).
- `RegDst` out 2: 00 rt, 01 rd, 10 $31.
- `NPCop` out 2: 00 PC+4, 01 branch target, 10 jump (instr_index), 11 GPR[rs].
- `RegWrite` out 1: GPR write enable.
- `Extop` out 1: 0 zero-extend, 1 sign-extend.
- `IRWrite` out 1: IR load enable.
- `PCWrite` out 1: PC load enable.
- `instr_done` out 1: one-cycle pulse in each instruction's final state.

## Operation
- Decoded set:
  - R-type (op 000000): addu (func 100001), subu (100011), jr (001000), sll/nop (000000). Any other func is treated as nop.
  - Other opcodes: ori 001101, lui 001111, lw 100011, sw 101011, beq 000100, j 000010, jal 000011.
  - Any other opcode is treated as nop.
- States are IF, ID, EX, MEM, WB, encoded 3 bits. The state register is the only required sequential state.
- Outputs are combinational from the state and the current inputs. Every output not listed for a state is 0.
- **IF**: `IRWrite`=1 → ID.
- **ID**:
  - j: `PCWrite`=1, `NPCop`=10 → IF.
  - jal: `PCWrite`=1, `NPCop`=10, `RegWrite`=1, `RegDst`=10, `MemtoReg`=10 → IF.
  - jr: `PCWrite`=1, `NPCop`=11 → IF.
  - nop / unknown: `PCWrite`=1, `NPCop`=00 → IF.
  - All other instructions → EX.
- **EX**:
  - addu: `ALUop`=0000, `ALU_SRC`=0 → WB.
  - subu: `ALUop`=0001, `ALU_SRC`=0 → WB.
  - ori: `ALUop`=0010, `ALU_SRC`=1, `Extop`=0 → WB.
  - lui: `ALUop`=0011, `ALU_SRC`=1, `Extop`=0 → WB.
  - lw/sw: `ALUop`=0000, `ALU_SRC`=1, `Extop`=1 → MEM.
  - beq: `ALUop`=0001, `ALU_SRC`=0, `Extop`=1, `PCWrite`=1, `NPCop`=01 if `ZERO` else 00 → IF.
- **MEM**: ALU controls are held at their EX values.
  - lw: `MemRead`=1 → WB.
  - sw: `MemWrite`=1, `PCWrite`=1, `NPCop`=00 → IF.
- **WB**: ALU controls are held at their EX values; `RegWrite`=1, `PCWrite`=1, `NPCop`=00.
  - addu/subu: `RegDst`=01, `MemtoReg`=00.
  - ori/lui: `RegDst`=00, `MemtoReg`=00.
  - lw: `RegDst`=00, `MemtoReg`=01, `MemRead`=1.
  - WB always → IF.
- `instr_done` is 1 exactly in the state that asserts `PCWrite`.

## Timing
- **Reset**: while `reset`=1, all outputs are forced to 0. On the next edge the state becomes IF, so the first cycle after reset deasserts is IF with `IRWrite`=1.
- **Reset mid-instruction**: the instruction is aborted. No `PCWrite`, `RegWrite` or `MemWrite` is asserted in the reset cycle, and fetch restarts from IF.
- **Cycles per instruction**: j/jal/jr/nop 2, beq 3, addu/subu/ori/lui/sw 4, lw 5.
- `Instruction_class` and `func` are sampled only from ID onward. The IR is stable after IF because `IRWrite` is 1 only in IF.
- `ZERO` is sampled only in EX of beq. It is combinational in the same cycle and is not registered.
- At most one of `PCWrite`/`IRWrite` is asserted per cycle. `MemRead` and `MemWrite` are never asserted together.
- State never leaves the {IF, ID, EX, MEM, WB} cycle. Unused encodings → IF on the next edge, with all outputs 0.

## Test plan
- **Reset**: hold `reset`=1 for 2 cycles with the op inputs at arbitrary values → all outputs are 0. Release → cycle 1 has `IRWrite`=1 and all other outputs 0.
- **addu** (op 000000, func 100001):
  - IF, ID, EX (`ALUop`=0000), WB (`RegWrite`=1, `RegDst`=01, `PCWrite`=1, `instr_done`=1).
  - Next instruction's `IRWrite` lands on cycle 5.
- **lw** (op 100011): 5 cycles.
  - MEM: `MemRead`=1.
  - WB: `MemtoReg`=01, `RegDst`=00, `RegWrite`=1, `Extop`=1.
  - `PCWrite` is asserted only in WB.
- **beq** (op 000100), run twice:
  - `ZERO`=1 → EX has `PCWrite`=1, `NPCop`=01.
  - `ZERO`=0 → EX has `PCWrite`=1, `NPCop`=00.
  - Both cases take 3 cycles with `RegWrite`=0 throughout.
- **jal** (000011), then **jr** (op 000000, func 001000):
  - jal ID: `NPCop`=10, `RegDst`=10, `MemtoReg`=10, `RegWrite`=1.
  - jr ID: `NPCop`=11, `RegWrite`=0.
  - Each takes 2 cycles.
- **Abort and illegal opcode**:
  - sw with `reset`=1 asserted in MEM → `MemWrite`=0 and `PCWrite`=0 that cycle; next cycle is IF.
  - Opcode 111111 → ID has `PCWrite`=1, `NPCop`=00; 2 cycles total.
